event_frame_packer: RTL and testbench

//  Downstream consumer of one processing unit's classifier output. Timestamps each

---
 rtl/event_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 51 +++++
 rtl/event_frame_packer.sv | 133 +++++++++++++
 tb/tb_event_frame_packer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared types and constants for the event framing path: entry layout, frame geometry, FSM states.
// Also provides the byte selector used to walk a frame out of the shadow register.
package event_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_BYTES   = 10;
    localparam int         TS_W          = 32;
    localparam int         EVT_W         = 32;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [EVT_W-1:0] ev;
    } evt_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_CSUM = 2'd3
    } pack_state_t;

    // Bytes 0..8 of a frame; the checksum byte is tracked separately.
    function automatic logic [7:0] frame_byte(
        input evt_entry_t e,
        input logic [3:0] idx,
        input logic [7:0] sync
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = sync;
            4'd1:    b = e.ts[31:24];
            4'd2:    b = e.ts[23:16];
            4'd3:    b = e.ts[15:8];
            4'd4:    b = e.ts[7:0];
            4'd5:    b = e.ev[31:24];
            4'd6:    b = e.ev[23:16];
            4'd7:    b = e.ev[15:8];
            4'd8:    b = e.ev[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/level; read data is the head entry taken straight from storage.
// Latency: a write is visible at the head the next cycle; pop advances the head at the clock edge.
// Backpressure: writes while full and reads while empty are ignored; full/empty reflect pre-edge state.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_vld,
    input  logic [WIDTH-1:0]       i_wr_dat,
    input  logic                   i_rd_vld,
    output logic [WIDTH-1:0]       o_rd_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level  = r_wr_ptr - r_rd_ptr;
    assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr = i_wr_vld && !o_full;
    assign w_rd = i_rd_vld && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/event_frame_packer.sv
// Timestamps qualified event words, buffers them and serialises each as a 10-byte checksummed frame.
// Latency: event into an empty, idle packer gives the first m_valid 3 cycles later; one LOAD cycle between frames.
// Backpressure: m_valid/m_data hold while m_ready is low; events arriving with the FIFO full are dropped and counted.
module event_frame_packer
    import event_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic                   event_valid,
    input  logic [EVT_W-1:0]       event_in,
    output logic                   m_valid,
    output logic [7:0]             m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam logic [3:0] LAST_DATA_IDX = 4'(FRAME_BYTES - 2);

    logic [TS_W-1:0] r_ts;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;
    pack_state_t     r_state;
    pack_state_t     w_state_nxt;
    evt_entry_t      r_shadow;
    logic [3:0]      r_idx;
    logic [7:0]      r_csum;

    evt_entry_t      w_wr_entry;
    evt_entry_t      w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_hs;

    // Events stamped in a sample_en cycle see the pre-increment count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else if (sample_en) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wr_entry = '{ts: r_ts, ev: event_in};
    assign w_push     = event_valid && !w_full;
    assign w_drop     = event_valid && w_full;
    assign w_pop      = (r_state == ST_LOAD);

    sync_fifo #(
        .WIDTH ($bits(evt_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_wr_vld (w_push),
        .i_wr_dat (w_wr_entry),
        .i_rd_vld (w_pop),
        .o_rd_dat (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    assign w_hs = m_valid && m_ready;

    always_comb begin
        w_state_nxt = r_state;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                m_valid = 1'b1;
                m_data  = frame_byte(r_shadow, r_idx, SYNC_BYTE);
                if (m_ready && (r_idx == LAST_DATA_IDX)) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                m_valid = 1'b1;
                m_data  = r_csum;
                if (m_ready) w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow register frees the FIFO slot as soon as a frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_csum   <= '0;
        end else if (r_state == ST_LOAD) begin
            r_shadow <= w_head;
            r_idx    <= '0;
            r_csum   <= '0;
        end else if ((r_state == ST_SEND) && w_hs) begin
            r_csum <= r_csum ^ m_data;
            r_idx  <= r_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_event_frame_packer.sv
// Bench for event_frame_packer: directed scenarios plus randomized traffic against a queue-based frame model.
module tb_event_frame_packer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic        event_valid;
    logic [31:0] event_in;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    event_frame_packer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .event_valid (event_valid),
        .event_in    (event_in),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_ts;
    logic [15:0] model_drop;
    logic        model_ovf;

    int          rx_cnt = 0;
    logic [79:0] rx_bits = '0;
    logic [79:0] last_frame = '0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_dat = '0;

    task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame = sync, ts (MSB first), ev (MSB first), XOR of those nine bytes.
    function automatic logic [79:0] build_frame(input logic [63:0] ent);
        logic [71:0] b;
        logic [7:0]  cs;
        b  = {SYNC, ent};
        cs = 8'h00;
        for (int i = 0; i < 9; i++) cs ^= b[8*i +: 8];
        return {b, cs};
    endfunction

    // Byte monitor: sampled on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        logic [63:0] ent;
        if (!rst) begin
            rx_cnt     = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_val("hold_valid", m_valid, 1'b1);
                check_val("hold_data", m_data, stall_dat);
            end
            stall_prev = m_valid && !m_ready;
            stall_dat  = m_data;
            if (m_valid && m_ready) begin
                rx_bits = {rx_bits[71:0], m_data};
                rx_cnt++;
                if (rx_cnt == 10) begin
                    last_frame = rx_bits;
                    rx_cnt     = 0;
                    if (exp_q.size() == 0) begin
                        check_val("spurious_frame", rx_bits, '0);
                    end else begin
                        ent = exp_q.pop_front();
                        check_val("frame", rx_bits, build_frame(ent));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; acc says whether the model expects the event to be stored.
    task automatic step(input logic se, input logic ev_v, input logic [31:0] ev, input logic acc);
        sample_en   = se;
        event_valid = ev_v;
        event_in    = ev;
        if (ev_v) begin
            if (acc) begin
                exp_q.push_back({model_ts, ev});
            end else begin
                model_ovf = 1'b1;
                if (model_drop != 16'hFFFF) model_drop++;
            end
        end
        if (se) model_ts++;
        @(posedge clk);
        #1;
        sample_en   = 1'b0;
        event_valid = 1'b0;
        event_in    = '0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) step(1'b0, 1'b0, '0, 1'b1);
        check_val({tag, "_drained"}, exp_q.size(), 0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] ev;
        rst = 1'b0; sample_en = 1'b0; event_valid = 1'b0; event_in = '0; m_ready = 1'b0;
        model_ts = '0; model_drop = '0; model_ovf = 1'b0;
        #12;
        check_val("rst_m_valid", m_valid, 1'b0);
        check_val("rst_m_data", m_data, 8'h00);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_drops", drop_count, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Single event at ts=5, latency and exact frame bytes.
        m_ready = 1'b1;
        repeat (5) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        check_val("lat_cycle1", m_valid, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check_val("lat_cycle2", m_valid, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check_val("lat_cycle3", m_valid, 1'b1);
        wait_done("t1", 40);
        check_val("t1_bytes", last_frame, 80'hA5_0000_0005_0000_0102_A3);
        check_val("t1_idle_valid", m_valid, 1'b0);
        check_val("t1_idle_level", fifo_level, 0);

        // Stall mid-frame for 7 cycles.
        step(1'b0, 1'b1, $urandom, 1'b1);
        for (int i = 0; i < 40 && rx_cnt < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        check_val("t2_reach_byte3", rx_cnt, 3);
        m_ready = 1'b0;
        repeat (7) step(1'b0, 1'b0, '0, 1'b1);
        check_val("t2_stall_valid", m_valid, 1'b1);
        check_val("t2_stall_count", rx_cnt, 3);
        m_ready = 1'b1;
        wait_done("t2", 40);

        // Timestamp wrap: stamped 0xFFFFFFFF in the sample_en cycle, then 0.
        force dut.r_ts = 32'hFFFF_FFFF;
        #1;
        release dut.r_ts;
        model_ts = 32'hFFFF_FFFF;
        step(1'b1, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1);
        wait_done("t4", 60);

        // Overflow: two stored before the first frame is shadowed, then DEPTH fill, last two dropped.
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++)
            step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'(i < DEPTH + 1));
        check_val("t3_level", fifo_level, DEPTH);
        check_val("t3_overflow", overflow, 1'b1);
        check_val("t3_drops", drop_count, model_drop);
        check_val("t3_drops_abs", drop_count, 2);

        // Finish the shadowed frame; push in the LOAD cycle while full is dropped.
        m_ready = 1'b1;
        repeat (10) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b0);
        check_val("t5_full_pop_level", fifo_level, DEPTH - 1);
        check_val("t5_full_pop_drops", drop_count, model_drop);
        repeat (10) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1);
        check_val("t5_push_pop_level", fifo_level, DEPTH - 1);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        check_val("t5_drained", exp_q.size(), 0);
        check_val("t5_back_to_back", n <= 175, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Random traffic, kept below capacity so every event must come out.
        for (int i = 0; i < 1500; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            ev = $urandom;
            if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 4) == 0)
                step(1'($urandom_range(0, 1)), 1'b1, ev, 1'b1);
            else
                step(1'($urandom_range(0, 1)), 1'b0, '0, 1'b1);
        end
        m_ready = 1'b1;
        wait_done("rand", DEPTH * 12 + 60);
        check_val("rand_drops", drop_count, model_drop);
        check_val("rand_overflow", overflow, model_ovf);

        // Reset at byte 4 with two events still buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom, 1'b1);
        for (int i = 0; i < 40 && rx_cnt < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        check_val("t6_reach_byte4", rx_cnt, 4);
        check_val("t6_pre_level", fifo_level, 2);
        #2 rst = 1'b0;
        #1;
        check_val("t6_async_valid", m_valid, 1'b0);
        check_val("t6_level", fifo_level, 0);
        check_val("t6_drops", drop_count, 0);
        check_val("t6_overflow", overflow, 1'b0);
        exp_q.delete();
        model_ts = '0; model_drop = '0; model_ovf = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        step(1'b0, 1'b1, $urandom, 1'b1);
        wait_done("t6", 40);
        check_val("t6_final_valid", m_valid, 1'b0);
        check_val("t6_final_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
